// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 256x8 sync-read memory between CPU (a_*) and
// video reader (b_*). Ports: clock, reset (async active-low),
// a_/b_ req/addr/we/wdata in, gnt/rvalid/rdata out, b_err out,
// mem_addr/mem_we/mem_wdata out, mem_rdata in.
// Option: define ARB_ROUND_ROBIN_EN for round-robin on contention,
// otherwise port A has fixed priority.
module mem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int VRAM_BASE = 128,
  parameter int VRAM_TOP  = 207
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  input  logic          a_we,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic [AW-1:0] b_addr,
  input  logic          b_we,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          b_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [AW-1:0] BASE = AW'(VRAM_BASE);
  localparam logic [AW-1:0] TOP  = AW'(VRAM_TOP);

  logic          a_el;
  logic          b_el;
  logic          b_oob;
  logic          win_a;
  logic          win_b;
  logic          a_pend;
  logic          b_pend;
  logic          a_gnt_d;
  logic          b_gnt_d;
  logic          b_err_d;
  logic          a_pend_d;
  logic          b_pend_d;
  logic          mem_we_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_wdata_d;

`ifdef ARB_ROUND_ROBIN_EN
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  port_t last_grant;
  port_t last_grant_d;
`endif

  always_comb begin
    // A port granted last cycle sits out this edge.
    a_el  = a_req & ~a_gnt;
    b_el  = b_req & ~b_gnt;
    b_oob = (b_addr < BASE) | (b_addr > TOP);
`ifdef ARB_ROUND_ROBIN_EN
    win_a = a_el
          & (~b_el | (last_grant == PORT_B));
    win_b = b_el
          & (~a_el | (last_grant == PORT_A));
    last_grant_d = last_grant;
    if (win_a)
      last_grant_d = PORT_A;
    else if (win_b)
      last_grant_d = PORT_B;
`else
    win_a = a_el;
    win_b = b_el & ~a_el;
`endif
    a_gnt_d     = win_a;
    b_gnt_d     = win_b;
    b_err_d     = win_b & b_oob;
    a_pend_d    = win_a & ~a_we;
    b_pend_d    = win_b & ~b_we & ~b_oob;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    unique case (1'b1)
      win_a: begin
        mem_addr_d  = a_addr;
        mem_wdata_d = a_wdata;
        mem_we_d    = a_we;
      end
      win_b: begin
        mem_addr_d  = b_addr;
        mem_wdata_d = b_wdata;
        // Out-of-window B accesses are issued as harmless reads.
        mem_we_d    = b_we & ~b_oob;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_gnt      <= 1'b0;
      b_gnt      <= 1'b0;
      b_err      <= 1'b0;
      a_pend     <= 1'b0;
      b_pend     <= 1'b0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= PORT_B;
`endif
    end else begin
      a_gnt      <= a_gnt_d;
      b_gnt      <= b_gnt_d;
      b_err      <= b_err_d;
      a_pend     <= a_pend_d;
      b_pend     <= b_pend_d;
      a_rvalid   <= a_pend;
      b_rvalid   <= b_pend;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= last_grant_d;
`endif
    end
  end

  assign a_rdata = mem_rdata;
  assign b_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random traffic on both ports, checked
// cycle by cycle against a transaction-level arbiter/memory model.
module tb_mem_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       a_req = 1'b0;
  logic [7:0] a_addr = '0;
  logic       a_we = 1'b0;
  logic [7:0] a_wdata = '0;
  logic       a_gnt;
  logic       a_rvalid;
  logic [7:0] a_rdata;
  logic       b_req = 1'b0;
  logic [7:0] b_addr = '0;
  logic       b_we = 1'b0;
  logic [7:0] b_wdata = '0;
  logic       b_gnt;
  logic       b_rvalid;
  logic [7:0] b_rdata;
  logic       b_err;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = '0;

  always #5 clock = ~clock;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_addr(a_addr),
    .a_we(a_we), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr),
    .b_we(b_we), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .b_rdata(b_rdata), .b_err(b_err),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37) + 11);
  endfunction

  logic [7:0] mem [256];
  logic [7:0] mm  [256];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = pat(i);
      mm[i]  = pat(i);
    end
  end

  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic [7:0] addr;
    logic       we;
    logic [7:0] wd;
  } acc_t;

  acc_t qa[$];
  acc_t qb[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Model expectations for the current cycle.
  logic       e_ag, e_bg, e_be, e_we;
  logic       e_arv, e_brv, e_ard, e_brd;
  logic       e_last;
  logic [7:0] e_addr, e_wd;
  logic [7:0] is_ad, is_bd, rv_ad, rv_bd;
  logic [7:0] cap_a, cap_b;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_ag = 0; e_bg = 0; e_be = 0; e_we = 0;
    e_arv = 0; e_brv = 0; e_ard = 0; e_brd = 0;
    e_last = 1;
    e_addr = 0; e_wd = 0;
    is_ad = 0; is_bd = 0; rv_ad = 0; rv_bd = 0;
  endtask

  task automatic drive();
    a_req = qa.size() > 0;
    b_req = qb.size() > 0;
    if (a_req) begin
      a_addr = qa[0].addr; a_we = qa[0].we;
      a_wdata = qa[0].wd;
    end else a_we = 0;
    if (b_req) begin
      b_addr = qb[0].addr; b_we = qb[0].we;
      b_wdata = qb[0].wd;
    end else b_we = 0;
  endtask

  // Next-cycle expectations from the inputs about to be sampled.
  task automatic predict();
    logic ael, bel, wa, wb, oob;
    e_arv = e_ard; rv_ad = is_ad;
    e_brv = e_brd; rv_bd = is_bd;
    ael = a_req && !e_ag;
    bel = b_req && !e_bg;
    oob = (b_addr < 8'd128) || (b_addr > 8'd207);
    wa = ael; wb = bel;
    if (ael && bel) begin
`ifdef ARB_ROUND_ROBIN_EN
      wa = e_last; wb = !e_last;
`else
      wa = 1; wb = 0;
`endif
    end
    e_ag = wa; e_bg = wb;
    e_be = wb && oob;
    e_ard = wa && !a_we;
    e_brd = wb && !b_we && !oob;
    e_we = 0;
    if (wa) begin
      e_addr = a_addr; e_wd = a_wdata; e_we = a_we;
      if (a_we) mm[a_addr] = a_wdata;
      is_ad = mm[a_addr];
      e_last = 0;
    end else if (wb) begin
      e_addr = b_addr; e_wd = b_wdata;
      e_we = b_we && !oob;
      if (e_we) mm[b_addr] = b_wdata;
      is_bd = mm[b_addr];
      e_last = 1;
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    chk("a_gnt", 32'(a_gnt), 32'(e_ag));
    chk("b_gnt", 32'(b_gnt), 32'(e_bg));
    chk("b_err", 32'(b_err), 32'(e_be));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    chk("a_rvalid", 32'(a_rvalid), 32'(e_arv));
    chk("b_rvalid", 32'(b_rvalid), 32'(e_brv));
    if (e_arv) begin
      chk("a_rdata", 32'(a_rdata), 32'(rv_ad));
      cap_a = a_rdata;
    end
    if (e_brv) begin
      chk("b_rdata", 32'(b_rdata), 32'(rv_bd));
      cap_b = b_rdata;
    end
    if (e_ag) void'(qa.pop_front());
    if (e_bg) void'(qb.pop_front());
    drive();
    predict();
  endtask

  task automatic drain();
    int k = 0;
    while ((qa.size() + qb.size()) > 0 && k < 200) begin
      cycle();
      k++;
    end
    chk("drain_timeout",
        32'(qa.size() + qb.size()), 0);
    cycle();
    cycle();
  endtask

  task automatic push_a(input logic [7:0] ad,
                        input logic we,
                        input logic [7:0] wd);
    acc_t t;
    t.addr = ad; t.we = we; t.wd = wd;
    qa.push_back(t);
  endtask

  task automatic push_b(input logic [7:0] ad,
                        input logic we,
                        input logic [7:0] wd);
    acc_t t;
    t.addr = ad; t.we = we; t.wd = wd;
    qb.push_back(t);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a_gnt"}, 32'(a_gnt), 0);
    chk({tag, "_b_gnt"}, 32'(b_gnt), 0);
    chk({tag, "_a_rv"}, 32'(a_rvalid), 0);
    chk({tag, "_b_rv"}, 32'(b_rvalid), 0);
    chk({tag, "_b_err"}, 32'(b_err), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wd"}, 32'(mem_wdata), 0);
  endtask

  initial begin
    bit hit;
    model_reset();
    cap_a = 0; cap_b = 0;
    repeat (2) @(negedge clock);
    chk_reset_vals("por");
    reset = 1;
    drive();
    predict();

    // A alone: write then read back.
    push_a(8'hF3, 1, 8'h5A);
    drain();
    cap_a = 0;
    push_a(8'hF3, 0, 8'h00);
    drain();
    chk("a_readback_F3", 32'(cap_a), 32'h5A);

    // Both held from idle: alternation.
    for (int i = 0; i < 4; i++) begin
      push_a(8'h10, 0, 0);
      push_b(8'h80, 0, 0);
    end
    drain();

    // Contention after a lone A grant.
    push_a(8'h11, 0, 0);
    drain();
    push_a(8'h12, 0, 0);
    push_b(8'h81, 0, 0);
    drain();

    // B window edges.
    cap_b = 0;
    push_b(8'd207, 0, 0);
    drain();
    chk("b_read_207", 32'(cap_b), 32'(pat(207)));
    push_b(8'd208, 1, 8'hFF);
    drain();
    chk("mem_208_kept", 32'(mem[208]), 32'(pat(208)));
    push_b(8'd127, 0, 0);
    drain();

    // Back-to-back write/read on A.
    cap_a = 0;
    push_a(8'h90, 1, 8'h11);
    push_a(8'h90, 0, 0);
    drain();
    chk("a_readback_90", 32'(cap_a), 32'h11);

    // Reset in the issue cycle of a read.
    push_a(8'h20, 0, 0);
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      cycle();
      hit = e_ag;
    end
    chk("rst_read_issued", 32'(hit), 1);
    @(posedge clock);
    #2;
    chk("rst_pre_gnt", 32'(a_gnt), 1);
    reset = 0;
    #1;
    chk_reset_vals("mid");
    model_reset();
    qa.delete();
    qb.delete();
    drive();
    @(negedge clock);
    reset = 1;
    predict();
    repeat (4) cycle();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      if (qa.size() < 2 && $urandom_range(0, 2) == 0)
        push_a(8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)),
               8'($urandom));
      if (qb.size() < 2 && $urandom_range(0, 2) == 0)
        push_b(8'($urandom_range(118, 217)),
               1'($urandom_range(0, 1)),
               8'($urandom));
      cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-port 256x8 synchronous-read system memory between the CPU (port A) and the video scan-out reader (port B). It issues at most one memory access per clock, returns read data with a valid strobe, and confines port B to the video window (addresses 128..207). It sits between both requesters and the memory macro; neither requester touches the memory directly.

## Interface
Parameters:
- AW, 8, address width
- DW, 8, data width
- VRAM_BASE, 128, lowest address port B may access
- VRAM_TOP, 207, highest address port B may access

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted, takes effect immediately, released synchronously to clock)
- a_req / b_req  in  1  access request, held until granted
- a_addr / b_addr  in  AW  access address, stable while req high
- a_we / b_we  in  1  1 = write, 0 = read
- a_wdata / b_wdata  in  DW  write data
- a_gnt / b_gnt  out  1  one-cycle pulse: access issued this cycle
- a_rvalid / b_rvalid  out  1  one-cycle pulse: a_rdata / b_rdata valid
- a_rdata / b_rdata  out  DW  read data, driven from mem_rdata
- b_err  out  1  one-cycle pulse with b_gnt when b_addr outside window
- mem_addr  out  AW  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after read issue

## Operation
- Grant decision made at each rising edge from sampled req; winner's addr/we/wdata registered onto mem_* and its gnt high for the following cycle (the issue cycle).
- Eligibility: a port is eligible at an edge if its req is high and its gnt is low during the cycle ending at that edge; a port is never granted in two consecutive cycles. Both ports may alternate, giving one access per cycle in total.
- Both eligible: winner chosen per Configuration. Only one eligible: it wins. None: mem_we driven 0, mem_addr/mem_wdata hold.
- Read (we=0) issued in cycle C: x_rvalid high in cycle C+1; x_rdata equals mem_rdata in that cycle. Write: no rvalid.
- Port B window check: b_addr < VRAM_BASE or > VRAM_TOP -> still granted (b_gnt pulse) with b_err pulse; mem_we forced 0, no b_rvalid. Port A unrestricted.
- Requester rule: drop req or present the next access at the edge ending its gnt cycle.
- State: last_grant pointer (A or B), registered gnt, registered read-pending flag per port.

## Timing
- Reset values: a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, b_err=0, mem_we=0, mem_addr=0, mem_wdata=0, last_grant=B.
- Latency req->gnt: 1 cycle when uncontended; worst case 2 cycles.
- Latency gnt->rvalid: 1 cycle.
- Reset asserted mid-access: all pulses and pending reads cleared immediately; no rvalid emitted for the interrupted read after release.
- x_rdata outside x_rvalid cycles is don't-care.

## Configuration
- ARB_ROUND_ROBIN_EN defined: when both eligible, the port not equal to last_grant wins; last_grant updated on every grant.
- Undefined: fixed priority, port A wins when both eligible; last_grant unused.

## Test plan
- Reset: drive reset=0 mid-read -> all outputs to reset values immediately; after release, no stray a_rvalid/b_rvalid.
- A alone: a_req=1, a_addr=0xF3, a_we=1, a_wdata=0x5A -> a_gnt one cycle after req, mem_addr=0xF3, mem_we=1, mem_wdata=0x5A in that cycle; read back 0xF3 -> a_rvalid next cycle after gnt, a_rdata=0x5A.
- Both held continuously from idle, distinct reads (A 0x10, B 0x80) -> grants alternate A,B,A,B each cycle (both configs, A first); no consecutive grants to one port.
- Contention after idle with last grant A: both raise req same edge -> round-robin: B first; fixed: A first.
- B window: b_addr=207 read -> b_rvalid, no err; b_addr=208 write 0xFF -> b_gnt with b_err, mem_we=0, location 208 unchanged; b_addr=127 -> b_err.
- Back-to-back A write 0x90=0x11 then read 0x90 -> read returns 0x11 with a_rvalid exactly one cycle after second a_gnt.
